// File: rtl/sram_bridge_pkg.sv
// Shared types and helpers for the two-port SRAM request/grant bridge.
// Holds width defaults, the port-index type and the SRAM window match.
package sram_bridge_pkg;

    localparam int ADDR_WIDTH_DEF = 13;
    localparam int DATA_WIDTH_DEF = 32;

    typedef enum logic {
        P_INSTR = 1'b0,
        P_DATA  = 1'b1
    } port_t;

    // True when the byte address falls inside the size-aligned window.
    function automatic logic in_window(
        input logic [31:0] addr,
        input logic [31:0] base,
        input int          aw
    );
        return (addr >> (aw + 2)) == (base >> (aw + 2));
    endfunction

endpackage

// File: rtl/sram_arb2.sv
// Two-requester arbiter: one-hot grant plus winner index.
// Ports: req_i, gnt_o, win_o (+ clk/rst_n with SRAM_ARB_RR_EN for round-robin).
module sram_arb2
    import sram_bridge_pkg::*;
(
`ifdef SRAM_ARB_RR_EN
    input  logic       clk,
    input  logic       rst_n,
`endif
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o,
    output port_t      win_o
);

    logic  conflict;
    port_t hi;

    assign conflict = req_i[0] & req_i[1];

`ifdef SRAM_ARB_RR_EN
    port_t prio;

    // Hand priority to the loser only when both ports competed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio <= P_INSTR;
        end else if (conflict) begin
            prio <= (win_o == P_INSTR) ? P_DATA : P_INSTR;
        end
    end

    assign hi = prio;
`else
    assign hi = P_INSTR;
`endif

    always_comb begin
        win_o = P_INSTR;
        gnt_o = 2'b00;
        unique case (1'b1)
            conflict:             win_o = hi;
            req_i[1] & ~req_i[0]: win_o = P_DATA;
            default:              win_o = P_INSTR;
        endcase
        if (|req_i) begin
            gnt_o = (win_o == P_DATA) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/sram_arb2_bridge.sv
// Arbitrates an instruction and a data port onto one single-port SRAM.
// Ports: p0_/p1_ req/gnt/addr/we/be/wdata/rvalid/rdata/err; sram_* pins.
// Define SRAM_ARB_RR_EN for round-robin, else port 0 has fixed priority.
module sram_arb2_bridge
    import sram_bridge_pkg::*;
#(
    parameter int          ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int          DATA_WIDTH = DATA_WIDTH_DEF,
    parameter logic [31:0] BASE_ADDR  = 32'h0010_0000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    p0_req_i,
    output logic                    p0_gnt_o,
    input  logic [31:0]             p0_addr_i,
    input  logic                    p0_we_i,
    input  logic [DATA_WIDTH/8-1:0] p0_be_i,
    input  logic [DATA_WIDTH-1:0]   p0_wdata_i,
    output logic                    p0_rvalid_o,
    output logic [DATA_WIDTH-1:0]   p0_rdata_o,
    output logic                    p0_err_o,
    input  logic                    p1_req_i,
    output logic                    p1_gnt_o,
    input  logic [31:0]             p1_addr_i,
    input  logic                    p1_we_i,
    input  logic [DATA_WIDTH/8-1:0] p1_be_i,
    input  logic [DATA_WIDTH-1:0]   p1_wdata_i,
    output logic                    p1_rvalid_o,
    output logic [DATA_WIDTH-1:0]   p1_rdata_o,
    output logic                    p1_err_o,
    output logic                    sram_cen_o,
    output logic                    sram_gwen_o,
    output logic [DATA_WIDTH/8-1:0] sram_ben_o,
    output logic [ADDR_WIDTH-1:0]   sram_a_o,
    output logic [DATA_WIDTH-1:0]   sram_d_o,
    input  logic [DATA_WIDTH-1:0]   sram_q_i
);

    localparam int BW = DATA_WIDTH / 8;

    logic [1:0]            req;
    logic [1:0]            gnt;
    port_t                 win;
    logic                  any_gnt;
    logic                  in_win;
    logic                  hit;
    logic [31:0]           sel_addr;
    logic                  sel_we;
    logic [BW-1:0]         sel_be;
    logic [DATA_WIDTH-1:0] sel_wdata;

    port_t                 owner;
    logic                  rvalid;
    logic                  is_read;
    logic                  err;

    assign req = {p1_req_i, p0_req_i};

    sram_arb2 u_arb (
`ifdef SRAM_ARB_RR_EN
        .clk   (clk),
        .rst_n (rst_n),
`endif
        .req_i (req),
        .gnt_o (gnt),
        .win_o (win)
    );

    assign p0_gnt_o = gnt[0];
    assign p1_gnt_o = gnt[1];
    assign any_gnt  = |gnt;

    // Winner defaults to port 0 when idle, so idle A/D track port 0.
    always_comb begin
        sel_addr  = p0_addr_i;
        sel_we    = p0_we_i;
        sel_be    = p0_be_i;
        sel_wdata = p0_wdata_i;
        if (win == P_DATA) begin
            sel_addr  = p1_addr_i;
            sel_we    = p1_we_i;
            sel_be    = p1_be_i;
            sel_wdata = p1_wdata_i;
        end
    end

    assign in_win = in_window(sel_addr, BASE_ADDR, ADDR_WIDTH);
    assign hit    = any_gnt & in_win;

    always_comb begin
        sram_cen_o  = 1'b1;
        sram_gwen_o = 1'b1;
        sram_ben_o  = '1;
        if (hit) begin
            sram_cen_o  = 1'b0;
            sram_gwen_o = ~sel_we;
            sram_ben_o  = sel_we ? ~sel_be : '0;
        end
    end

    assign sram_a_o = sel_addr[ADDR_WIDTH+1:2];
    assign sram_d_o = sel_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid  <= 1'b0;
            owner   <= P_INSTR;
            is_read <= 1'b0;
            err     <= 1'b0;
        end else begin
            rvalid <= any_gnt;
            if (any_gnt) begin
                owner   <= win;
                is_read <= ~sel_we;
                err     <= ~in_win;
            end
        end
    end

    assign p0_rvalid_o = rvalid && (owner == P_INSTR);
    assign p1_rvalid_o = rvalid && (owner == P_DATA);
    assign p0_err_o    = p0_rvalid_o && err;
    assign p1_err_o    = p1_rvalid_o && err;
    assign p0_rdata_o  = (p0_rvalid_o && is_read && !err) ? sram_q_i : '0;
    assign p1_rdata_o  = (p1_rvalid_o && is_read && !err) ? sram_q_i : '0;

endmodule

// File: tb/tb_sram_arb2_bridge.sv
// Directed scoreboard bench for sram_arb2_bridge with a behavioural SRAM.
// Honours SRAM_ARB_RR_EN for the expected conflict grant order.
module tb_sram_arb2_bridge;

    logic        clk;
    logic        rst_n;
    logic        p0_req, p0_gnt, p0_we, p0_rvalid, p0_err;
    logic [31:0] p0_addr, p0_wdata, p0_rdata;
    logic [3:0]  p0_be;
    logic        p1_req, p1_gnt, p1_we, p1_rvalid, p1_err;
    logic [31:0] p1_addr, p1_wdata, p1_rdata;
    logic [3:0]  p1_be;
    logic        cen, gwen;
    logic [3:0]  ben;
    logic [12:0] sa;
    logic [31:0] sd, sq;

    logic [31:0] mem [0:8191];

    typedef struct {
        bit          port;
        logic [31:0] data;
        bit          err;
    } resp_t;

    resp_t       sb[$];
    logic [31:0] exp_mem [int];
    int          total  = 0;
    int          passed = 0;

    sram_arb2_bridge dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .p0_req_i    (p0_req),
        .p0_gnt_o    (p0_gnt),
        .p0_addr_i   (p0_addr),
        .p0_we_i     (p0_we),
        .p0_be_i     (p0_be),
        .p0_wdata_i  (p0_wdata),
        .p0_rvalid_o (p0_rvalid),
        .p0_rdata_o  (p0_rdata),
        .p0_err_o    (p0_err),
        .p1_req_i    (p1_req),
        .p1_gnt_o    (p1_gnt),
        .p1_addr_i   (p1_addr),
        .p1_we_i     (p1_we),
        .p1_be_i     (p1_be),
        .p1_wdata_i  (p1_wdata),
        .p1_rvalid_o (p1_rvalid),
        .p1_rdata_o  (p1_rdata),
        .p1_err_o    (p1_err),
        .sram_cen_o  (cen),
        .sram_gwen_o (gwen),
        .sram_ben_o  (ben),
        .sram_a_o    (sa),
        .sram_d_o    (sd),
        .sram_q_i    (sq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!cen) begin
            if (!gwen) begin
                for (int b = 0; b < 4; b++) begin
                    if (!ben[b]) mem[sa][b*8 +: 8] <= sd[b*8 +: 8];
                end
            end else begin
                sq <= mem[sa];
            end
        end
    end

    task automatic check32(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic push(input bit port);
        logic [31:0] a, wd, old;
        logic [3:0]  be;
        logic        we;
        resp_t       r;
        int          w;
        a  = port ? p1_addr : p0_addr;
        wd = port ? p1_wdata : p0_wdata;
        be = port ? p1_be : p0_be;
        we = port ? p1_we : p0_we;
        r.port = port;
        r.err  = (a[31:15] != 17'h00020);
        r.data = 32'h0;
        w = int'(a[14:2]);
        if (!r.err) begin
            if (we) begin
                old = exp_mem.exists(w) ? exp_mem[w] : 32'h0;
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) old[b*8 +: 8] = wd[b*8 +: 8];
                end
                exp_mem[w] = old;
            end else begin
                r.data = exp_mem[w];
            end
        end
        sb.push_back(r);
    endtask

    task automatic tick(input logic eg0, input logic eg1);
        resp_t r;
        #1;
        check1("gnt0", p0_gnt, eg0);
        check1("gnt1", p1_gnt, eg1);
        if (eg0) push(1'b0);
        if (eg1) push(1'b1);
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            r = sb.pop_front();
            check1("rvalid0", p0_rvalid, r.port == 1'b0);
            check1("rvalid1", p1_rvalid, r.port == 1'b1);
            check32("rdata0", p0_rdata, (r.port == 1'b0) ? r.data : 32'h0);
            check32("rdata1", p1_rdata, (r.port == 1'b1) ? r.data : 32'h0);
            check1("err0", p0_err, (r.port == 1'b0) && r.err);
            check1("err1", p1_err, (r.port == 1'b1) && r.err);
        end else begin
            check1("idle_rvalid0", p0_rvalid, 1'b0);
            check1("idle_rvalid1", p1_rvalid, 1'b0);
        end
    endtask

    task automatic pins(input logic ecen, input logic egwen,
                        input logic [3:0] eben, input logic [12:0] ea);
        #1;
        check1("cen", cen, ecen);
        check1("gwen", gwen, egwen);
        check32("ben", 32'(ben), 32'(eben));
        check32("sram_a", 32'(sa), 32'(ea));
    endtask

    task automatic reset_vals();
        check1("rst_rvalid0", p0_rvalid, 1'b0);
        check1("rst_rvalid1", p1_rvalid, 1'b0);
        check1("rst_err0", p0_err, 1'b0);
        check1("rst_err1", p1_err, 1'b0);
        check32("rst_rdata0", p0_rdata, 32'h0);
        check32("rst_rdata1", p1_rdata, 32'h0);
        check1("rst_gnt0", p0_gnt, 1'b0);
        check1("rst_gnt1", p1_gnt, 1'b0);
        check1("rst_cen", cen, 1'b1);
        check1("rst_gwen", gwen, 1'b1);
        check32("rst_ben", 32'(ben), 32'hF);
    endtask

    initial begin
        rst_n = 1'b0;
        p0_req = 0; p0_we = 0; p0_be = 0; p0_addr = 0; p0_wdata = 0;
        p1_req = 0; p1_we = 0; p1_be = 0; p1_addr = 0; p1_wdata = 0;
        repeat (2) @(posedge clk);
        #1;
        reset_vals();
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Write then read through port 1.
        p1_req = 1; p1_we = 1; p1_be = 4'hF;
        p1_addr = 32'h0010_0040; p1_wdata = 32'hDEAD_BEEF;
        pins(1'b0, 1'b0, 4'h0, 13'h010);
        tick(1'b0, 1'b1);
        p1_we = 0;
        pins(1'b0, 1'b1, 4'h0, 13'h010);
        tick(1'b0, 1'b1);

        // Byte write into a preloaded word.
        p1_we = 1; p1_be = 4'hF;
        p1_addr = 32'h0010_0080; p1_wdata = 32'h1122_3344;
        tick(1'b0, 1'b1);
        p1_be = 4'b0100; p1_wdata = 32'h00AB_0000;
        pins(1'b0, 1'b0, 4'b1011, 13'h020);
        tick(1'b0, 1'b1);
        p1_we = 0;
        tick(1'b0, 1'b1);
        check32("byte_merge", exp_mem[32], 32'h11AB_3344);

        // Fill 8 words back-to-back, then read them back-to-back on port 0.
        for (int i = 0; i < 8; i++) begin
            p1_we = 1; p1_be = 4'hF;
            p1_addr = 32'h0010_0100 + 32'(i * 4);
            p1_wdata = 32'h0101_0101 * 32'(i) + 32'h5A;
            tick(1'b0, 1'b1);
        end
        p1_req = 0; p1_we = 0;
        for (int i = 0; i < 8; i++) begin
            p0_req = 1; p0_we = 0;
            p0_addr = 32'h0010_0100 + 32'(i * 4);
            tick(1'b1, 1'b0);
        end
        p0_req = 0;
        tick(1'b0, 1'b0);

        // Conflict: port 0 reads, port 1 writes, both held for 4 cycles.
        p0_req = 1; p0_we = 0; p0_addr = 32'h0010_0104;
        p1_req = 1; p1_we = 1; p1_be = 4'hF;
        p1_addr = 32'h0010_0200; p1_wdata = 32'hC0FF_EE00;
        for (int i = 0; i < 4; i++) begin
`ifdef SRAM_ARB_RR_EN
            tick((i % 2) == 0, (i % 2) == 1);
`else
            tick(1'b1, 1'b0);
`endif
        end
        p0_req = 0; p1_req = 0; p1_we = 0;
        tick(1'b0, 1'b0);

        // Out-of-window read on port 0.
        p0_req = 1; p0_we = 0; p0_addr = 32'h0000_1000;
        #1;
        check1("oow_cen", cen, 1'b1);
        tick(1'b1, 1'b0);
        p0_req = 0;

        // Reset while a port 1 read is pending.
        p1_req = 1; p1_we = 0; p1_addr = 32'h0010_0040;
        tick(1'b0, 1'b1);
        p1_addr = 32'h0010_0080;
        #1;
        check1("mid_gnt1", p1_gnt, 1'b1);
        check1("mid_rvalid_pre", p1_rvalid, 1'b1);
        rst_n = 1'b0;
        p1_req = 0;
        #1;
        check1("mid_rvalid_async", p1_rvalid, 1'b0);
        @(posedge clk);
        #1;
        reset_vals();
        rst_n = 1'b1;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        check32("sb_empty", 32'(sb.size()), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
